// File: rtl/reg_scoreboard_pkg.sv
// rtl/reg_scoreboard_pkg.sv - shared types and helpers for the register scoreboard
//
// Purpose: address-width helper, default geometry and the forward-source
// record that the operand resolver consumes.
// Ports: none (package).
package sb_pkg;

  // Register-address width for a given register count (at least 1 bit).
  function automatic int addr_w(input int nreg);
    return (nreg > 2) ? $clog2(nreg) : 1;
  endfunction

  localparam int SB_NREG = 32;
  localparam int SB_DW   = 32;
  localparam int SB_AW   = addr_w(SB_NREG);

  // One forwarding source as seen by ID; field order fixes the packed layout.
  typedef struct packed {
    logic             valid;
    logic             ready;
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } fwd_src_t;

endpackage

// File: rtl/reg_scoreboard_if.sv
// rtl/reg_scoreboard_if.sv - issue/retire/flush and operand-query bundle of the scoreboard
//
// Purpose: groups every non-clock/reset signal of reg_scoreboard.
// master: ID/EXE/WB pipeline side (drives issue, retire, flush, reads, forwards).
// slave : scoreboard side (returns issue_ready, rd_data, rd_stall, underflow_err).
interface reg_scoreboard_if #(
  parameter int NREG = 32,
  parameter int DW   = 32,
  parameter int NRD  = 2,
  parameter int NFWD = 3
);
  localparam int AW = sb_pkg::addr_w(NREG);

  logic                issue_valid;
  logic                issue_we;
  logic [AW-1:0]       issue_dest;
  logic                issue_ready;
  logic                wb_valid;
  logic [AW-1:0]       wb_dest;
  logic                flush;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD-1:0]      rd_en;
  logic [NRD*DW-1:0]   rf_rdata;
  logic [NFWD-1:0]     fwd_valid;
  logic [NFWD*AW-1:0]  fwd_addr;
  logic [NFWD-1:0]     fwd_ready;
  logic [NFWD*DW-1:0]  fwd_data;
  logic [NRD*DW-1:0]   rd_data;
  logic                rd_stall;
  logic                underflow_err;

  modport master (
    output issue_valid, issue_we, issue_dest, wb_valid, wb_dest, flush,
           rd_addr, rd_en, rf_rdata, fwd_valid, fwd_addr, fwd_ready, fwd_data,
    input  issue_ready, rd_data, rd_stall, underflow_err
  );

  modport slave (
    input  issue_valid, issue_we, issue_dest, wb_valid, wb_dest, flush,
           rd_addr, rd_en, rf_rdata, fwd_valid, fwd_addr, fwd_ready, fwd_data,
    output issue_ready, rd_data, rd_stall, underflow_err
  );

endinterface

// File: rtl/reg_scoreboard_fwd_select.sv
// rtl/reg_scoreboard_fwd_select.sv - operand resolver for one ID read port
//
// Purpose: picks RF data, the youngest matching forward source, or a stall.
// Ports: en/addr/rf_rdata (read request + RF value), src (forward sources,
// index 0 youngest), pending (scoreboard count for addr is non-zero),
// data/stall (resolved operand and hold request).
module fwd_select
  import sb_pkg::*;
#(
  parameter int NFWD = 3
) (
  input  logic                       en,
  input  logic [SB_AW-1:0]           addr,
  input  logic [SB_DW-1:0]           rf_rdata,
  input  fwd_src_t [NFWD-1:0]        src,
  input  logic                       pending,
  output logic [SB_DW-1:0]           data,
  output logic                       stall
);

  logic hit;

  always_comb begin
    data  = rf_rdata;
    stall = 1'b0;
    hit   = 1'b0;
    // r0 never has a writer; unused ports never stall.
    if (en && addr != '0) begin
      for (int j = 0; j < NFWD; j++) begin
        if (!hit && src[j].valid && src[j].addr == addr) begin
          hit = 1'b1;
          if (src[j].ready) data  = src[j].data;
          else              stall = 1'b1;
        end
      end
      // Writer exists but sits where no forward path reaches (e.g. inside a divider).
      if (!hit && pending) stall = 1'b1;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending counters with forward select for the ID stage
//
// Purpose: counts in-flight writers per GPR (issue increments, WB retire
// decrements, flush clears) and resolves each ID read to RF / forward / stall.
// Ports: clk, resetn (sync active-low), sb (reg_scoreboard_if slave):
// issue_* (ID->EXE issue + back-pressure), wb_* (retire), flush,
// rd_* / rf_rdata (operand query), fwd_* (forward sources), underflow_err.
module reg_scoreboard
  import sb_pkg::*;
#(
  parameter int NREG  = SB_NREG,
  parameter int DW    = SB_DW,
  parameter int NRD   = 2,
  parameter int NFWD  = 3,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            resetn,
  reg_scoreboard_if.slave sb
);

  localparam int AW = addr_w(NREG);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]     cnt [NREG];
  logic                 err_q;
  logic                 inc;
  logic                 dec;
  logic [NREG-1:0]      inc_vec;
  logic [NREG-1:0]      dec_vec;
  logic                 underflow_hit;
  fwd_src_t [NFWD-1:0]  srcs;
  logic [NRD-1:0]       port_stall;
  logic [DW-1:0]        port_data [NRD];

  // Issue is refused only when it would overflow the destination's counter.
  assign sb.issue_ready = !(sb.issue_we && sb.issue_dest != '0 &&
                            cnt[sb.issue_dest] == CNT_MAX);
  assign inc = sb.issue_valid && sb.issue_ready && sb.issue_we && sb.issue_dest != '0;
  assign dec = sb.wb_valid && sb.wb_dest != '0;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (inc) inc_vec[sb.issue_dest] = 1'b1;
    if (dec) dec_vec[sb.wb_dest]    = 1'b1;
  end

  // A same-register issue cancels the retire, so it is not an underflow.
  assign underflow_hit = dec && cnt[sb.wb_dest] == '0 && !inc_vec[sb.wb_dest];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      err_q <= 1'b0;
    end else if (sb.flush) begin
      // Error flag survives a flush; only reset clears it.
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (inc_vec[r] && !dec_vec[r])
          cnt[r] <= cnt[r] + CNT_W'(1);
        else if (dec_vec[r] && !inc_vec[r] && cnt[r] != '0)
          cnt[r] <= cnt[r] - CNT_W'(1);
      end
      if (underflow_hit) err_q <= 1'b1;
    end
  end

  assign sb.underflow_err = err_q;

  for (genvar j = 0; j < NFWD; j++) begin : g_src
    assign srcs[j] = {sb.fwd_valid[j], sb.fwd_ready[j],
                      sb.fwd_addr[j*AW +: AW], sb.fwd_data[j*DW +: DW]};
  end

  for (genvar i = 0; i < NRD; i++) begin : g_port
    logic [AW-1:0] addr_i;
    assign addr_i = sb.rd_addr[i*AW +: AW];

    fwd_select #(.NFWD(NFWD)) u_sel (
      .en       (sb.rd_en[i]),
      .addr     (addr_i),
      .rf_rdata (sb.rf_rdata[i*DW +: DW]),
      .src      (srcs),
      .pending  (cnt[addr_i] != '0),
      .data     (port_data[i]),
      .stall    (port_stall[i])
    );

    assign sb.rd_data[i*DW +: DW] = port_data[i];
  end

  assign sb.rd_stall = |port_stall;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - scoreboard-checked random and directed bench for reg_scoreboard
module tb_reg_scoreboard;
  import sb_pkg::*;

  localparam int NREG  = 32;
  localparam int DW    = 32;
  localparam int NRD   = 2;
  localparam int NFWD  = 3;
  localparam int CNT_W = 2;
  localparam int AW    = addr_w(NREG);
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  reg_scoreboard_if #(.NREG(NREG), .DW(DW), .NRD(NRD), .NFWD(NFWD)) sb ();

  reg_scoreboard #(.NREG(NREG), .DW(DW), .NRD(NRD), .NFWD(NFWD), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .sb     (sb.slave)
  );

  typedef struct packed {
    logic                      rst_n;
    logic                      iv;
    logic                      iwe;
    logic [AW-1:0]             idest;
    logic                      wv;
    logic [AW-1:0]             wdest;
    logic                      flush;
    logic [NRD-1:0][AW-1:0]    raddr;
    logic [NRD-1:0]            ren;
    logic [NFWD-1:0]           fv;
    logic [NFWD-1:0]           fr;
    logic [NFWD-1:0][AW-1:0]   faddr;
    logic [NFWD-1:0][DW-1:0]   fdata;
  } stim_t;

  typedef struct packed {
    logic                    ready;
    logic                    stall;
    logic                    err;
    logic [NRD-1:0]          pstall;
    logic [NRD-1:0][DW-1:0]  data;
  } exp_t;

  stim_t s;              // being composed
  stim_t c;              // currently driven
  exp_t  exp_q [$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // Reference model: writer counts, sticky error, architectural regfile.
  int          pend [NREG];
  bit          m_err;
  logic [DW-1:0] rf_mem [NREG];

  function automatic bit m_ready();
    return !(c.iwe && c.idest != 0 && pend[c.idest] == CMAX);
  endfunction

  initial begin
    c = '0;
    s = '0;
    m_err = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      pend[r]   = 0;
      rf_mem[r] = (r == 0) ? '0 : DW'($urandom);
    end
  end

  // Model commits whatever the DUT saw on this edge.
  always @(posedge clk) begin
    bit inc, dec;
    if (!c.rst_n) begin
      for (int r = 0; r < NREG; r++) pend[r] = 0;
      m_err = 1'b0;
    end else if (c.flush) begin
      for (int r = 0; r < NREG; r++) pend[r] = 0;
    end else begin
      inc = c.iv && m_ready() && c.iwe && c.idest != 0;
      dec = c.wv && c.wdest != 0;
      if (!(inc && dec && c.idest == c.wdest)) begin
        if (inc) pend[c.idest] = pend[c.idest] + 1;
        if (dec) begin
          if (pend[c.wdest] == 0) m_err = 1'b1;
          else pend[c.wdest] = pend[c.wdest] - 1;
        end
      end
      if (dec) rf_mem[c.wdest] = DW'($urandom);
    end
  end

  function automatic exp_t predict();
    exp_t e;
    e = '0;
    e.ready = m_ready();
    e.err   = m_err;
    for (int i = 0; i < NRD; i++) begin
      int a;
      bit found;
      a = int'(c.raddr[i]);
      e.data[i] = rf_mem[a];
      found = 1'b0;
      if (c.ren[i] && a != 0) begin
        for (int j = 0; j < NFWD; j++) begin
          if (!found && c.fv[j] && int'(c.faddr[j]) == a) begin
            found = 1'b1;
            if (c.fr[j]) e.data[i] = c.fdata[j];
            else e.pstall[i] = 1'b1;
          end
        end
        if (!found && pend[a] != 0) e.pstall[i] = 1'b1;
      end
    end
    e.stall = |e.pstall;
    return e;
  endfunction

  task automatic drive();
    resetn         = c.rst_n;
    sb.issue_valid = c.iv;
    sb.issue_we    = c.iwe;
    sb.issue_dest  = c.idest;
    sb.wb_valid    = c.wv;
    sb.wb_dest     = c.wdest;
    sb.flush       = c.flush;
    sb.rd_addr     = c.raddr;
    sb.rd_en       = c.ren;
    sb.fwd_valid   = c.fv;
    sb.fwd_ready   = c.fr;
    sb.fwd_addr    = c.faddr;
    sb.fwd_data    = c.fdata;
    for (int i = 0; i < NRD; i++) sb.rf_rdata[i*DW +: DW] = rf_mem[c.raddr[i]];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    c = s;
    drive();
    exp_q.push_back(predict());
  endtask

  task automatic idle();
    s = '0;
    s.rst_n = 1'b1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: the query path is combinational, so every cycle presents an output.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("issue_ready", 64'(sb.issue_ready), 64'(e.ready));
      chk("rd_stall", 64'(sb.rd_stall), 64'(e.stall));
      chk("underflow_err", 64'(sb.underflow_err), 64'(e.err));
      for (int i = 0; i < NRD; i++)
        if (!e.pstall[i]) chk($sformatf("rd_data%0d", i), 64'(sb.rd_data[i*DW +: DW]), 64'(e.data[i]));
    end
  end

  function automatic int pick_wdest();
    if ($urandom_range(0, 9) < 7) begin
      for (int t = 0; t < 8; t++) begin
        int r;
        r = $urandom_range(1, 7);
        if (pend[r] != 0) return r;
      end
    end
    return $urandom_range(0, 7);
  endfunction

  initial begin
    c = '0;
    drive();

    // Reset held two cycles with a retire pending.
    idle(); s.rst_n = 1'b0; s.wv = 1'b1; s.wdest = AW'(5);
    step(); step();
    idle(); s.ren = '1; s.raddr[0] = AW'(5); s.raddr[1] = AW'(6);
    step();

    // Forward priority: youngest matching source wins.
    idle();
    s.fv = 3'b011; s.fr = 3'b011;
    s.faddr[0] = AW'(5); s.fdata[0] = DW'(32'hAAAA);
    s.faddr[1] = AW'(5); s.fdata[1] = DW'(32'hBBBB);
    s.ren = 2'b01; s.raddr[0] = AW'(5);
    step();

    // Load-use: not ready then ready.
    idle(); s.fv = 3'b001; s.faddr[0] = AW'(7); s.fdata[0] = DW'(32'h1234_5678);
    s.ren = 2'b01; s.raddr[0] = AW'(7);
    step();
    s.fr = 3'b001;
    step();

    // Multi-cycle writers on r3: two issues, issue+retire, third issue, refused fourth.
    idle(); s.iv = 1'b1; s.iwe = 1'b1; s.idest = AW'(3);
    step(); step();
    s.wv = 1'b1; s.wdest = AW'(3);
    step();
    s.wv = 1'b0;
    step();
    s.ren = 2'b10; s.raddr[1] = AW'(3);
    step();
    step();
    // Drain r3 with no forward hit: stalls until the third retire lands.
    idle(); s.ren = 2'b01; s.raddr[0] = AW'(3); s.wv = 1'b1; s.wdest = AW'(3);
    repeat (3) step();
    s.wv = 1'b0;
    step();

    // Flush with a same-cycle retire and issue.
    idle(); s.iv = 1'b1; s.iwe = 1'b1; s.idest = AW'(4);
    step();
    s.idest = AW'(9);
    step();
    s.flush = 1'b1; s.wv = 1'b1; s.wdest = AW'(4);
    s.ren = 2'b11; s.raddr[0] = AW'(4); s.raddr[1] = AW'(9);
    step();
    s.flush = 1'b0; s.wv = 1'b0; s.iv = 1'b0;
    step();

    // r0 is never pending; retire on an empty counter sets the sticky error.
    idle(); s.iv = 1'b1; s.iwe = 1'b1; s.idest = AW'(0);
    s.fv = 3'b001; s.faddr[0] = AW'(0);
    s.ren = 2'b11; s.raddr[0] = AW'(0); s.raddr[1] = AW'(0);
    step();
    s.iv = 1'b0;
    step();
    idle(); s.wv = 1'b1; s.wdest = AW'(6);
    step();
    idle();
    step();
    s.flush = 1'b1;
    step();
    s.flush = 1'b0;
    step();

    // Randomized traffic.
    idle(); s.rst_n = 1'b0;
    step();
    for (int n = 0; n < 600; n++) begin
      idle();
      s.rst_n = ($urandom_range(0, 99) != 0);
      s.flush = ($urandom_range(0, 39) == 0);
      s.iv    = $urandom_range(0, 1);
      s.iwe   = ($urandom_range(0, 3) != 0);
      s.idest = AW'($urandom_range(0, 7));
      s.wv    = ($urandom_range(0, 2) == 0);
      s.wdest = AW'(pick_wdest());
      for (int i = 0; i < NRD; i++) begin
        s.ren[i]   = ($urandom_range(0, 3) != 0);
        s.raddr[i] = AW'($urandom_range(0, 7));
      end
      for (int j = 0; j < NFWD; j++) begin
        s.fv[j]    = $urandom_range(0, 1);
        s.fr[j]    = ($urandom_range(0, 3) != 0);
        s.faddr[j] = AW'($urandom_range(0, 7));
        s.fdata[j] = DW'($urandom);
      end
      step();
    end

    // Closing reset clears the error flag.
    idle(); s.rst_n = 1'b0;
    step();
    idle();
    step();

    begin
      int waited;
      waited = 0;
      while (exp_q.size() > 0 && waited < 10) begin
        @(negedge clk);
        #1;
        waited++;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
